ifu_prefetch: RTL and testbench

IFU_PREFETCH -- requirements
Module: ifu_prefetch

---
 rtl/ifu_pkg.sv | 24 ++
 rtl/ifu_fifo.sv | 80 ++++++++
 rtl/ifu_prefetch.sv | 163 ++++++++++++++++
 tb/tb_ifu_prefetch.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch prefetch unit.
package ifu_pkg;

  // Default program-counter / address width.
  localparam int unsigned XLEN_DEFAULT = 32;

  // Every fetched instruction word is four bytes; PCs advance by this step.
  localparam int unsigned INST_BYTES = 4;

  // Width of one instruction word returned by the memory.
  localparam int unsigned INST_W = 32;

  // Fetch control: RUN when no flushed response is owed, DRAIN otherwise.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // Width of a counter that must hold every value from 0 up to depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with single-cycle flush, used as the prefetch queue.
// Head data reads as zero while the queue is empty.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned  WIDTH = 64,
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // Flush takes priority over both push and pop.
  assign do_pop  = pop && !empty && !flush;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);

  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage array write port.
  // NOTE: the data array is deliberately left without reset; only the pointers
  // and count are reset, and head_data is masked while empty, so stale
  // contents can never reach the outputs.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; a flush empties the queue in one cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Writes into a full queue would lose data; the credit scheme upstream
  // guarantees this never happens.
  assert property (@(posedge clock) disable iff (reset)
                   !(push && !flush && full && !do_pop));

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues sequential fetch requests under a credit
// limit, queues in-order responses with their PCs, and handles redirects by
// flushing the queue and discarding responses owed to abandoned requests.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_code,
  output logic [XLEN-1:0]   inst_pc,
  output logic [XLEN-1:0]   fetch_pc
);

  localparam int unsigned     CW   = cnt_width(DEPTH);
  localparam int unsigned     SW   = CW + 2;
  localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);

  fetch_state_e state;

  logic [XLEN-1:0]        rsp_pc;
  logic [XLEN-1:0]        redirect_target;
  logic [CW-1:0]          q_count;
  logic [CW-1:0]          live_cnt;
  logic [CW-1:0]          drop_cnt;
  logic [CW-1:0]          live_nxt;
  logic [CW-1:0]          drop_nxt;
  logic [SW-1:0]          occupancy;
  logic                   credit_ok;
  logic                   req_fire;
  logic                   rsp_keep;
  logic                   rsp_drain;
  logic                   pop;
  logic [XLEN+INST_W-1:0] head_data;

  // Redirect targets are forced onto an instruction boundary.
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // Queue slots already filled plus every response still in flight, whether it
  // will be kept or discarded, must leave room for one more request.
  assign occupancy = SW'(q_count) + SW'(live_cnt) + SW'(drop_cnt);
  assign credit_ok = (occupancy < SW'(DEPTH));

  // Depends only on state and redirect_valid, never on mem_req_ready.
  assign mem_req_valid = !reset && !redirect_valid && credit_ok;
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response is kept only when nothing is owed to a flushed request and no
  // redirect flushes it in the same cycle.
  assign rsp_keep  = mem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign rsp_drain = mem_rsp_valid && !redirect_valid && (drop_cnt != '0);

  // A redirect in the same cycle as a consume wins: the head is flushed, not popped.
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign inst_valid = (q_count != '0);

  ifu_fifo #(
    .WIDTH (XLEN + INST_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({rsp_pc, mem_rsp_data}),
    .pop       (pop),
    .head_data (head_data),
    .count     (q_count)
  );

  assign {inst_pc, inst_code} = head_data;

  // Next values of the live and owed-response counters.
  // NOTE: every signal assigned here gets its default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    live_nxt = live_cnt;
    drop_nxt = drop_cnt;
    if (redirect_valid) begin
      // Every live request becomes owed; a response arriving now settles one of them.
      live_nxt = '0;
      drop_nxt = drop_cnt + live_cnt;
      if (mem_rsp_valid && (drop_nxt != '0)) begin
        drop_nxt = drop_nxt - 1'b1;
      end
    end else begin
      if (req_fire) begin
        live_nxt = live_nxt + 1'b1;
      end
      if (rsp_keep) begin
        live_nxt = live_nxt - 1'b1;
      end
      if (rsp_drain) begin
        drop_nxt = drop_cnt - 1'b1;
      end
    end
  end

  // Request-side address: advances per accepted request, reloads on redirect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + STEP;
    end
  end

  // Response-side PC tag: follows the request stream one kept response at a time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      rsp_pc <= redirect_target;
    end else if (rsp_keep) begin
      rsp_pc <= rsp_pc + STEP;
    end
  end

  // Fetch FSM with its counters: DRAIN while flushed responses are still owed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      live_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      live_cnt <= live_nxt;
      drop_cnt <= drop_nxt;
      case (state)
        RUN: begin
          if (redirect_valid && (drop_nxt != '0)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drop_nxt == '0) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // The state flag and the owed-response counter always agree.
  assert property (@(posedge clock) disable iff (reset)
                   (state == DRAIN) == (drop_cnt != '0));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: a transaction-level model (request
// queue tagged with redirect epochs, instruction queue) predicts every output
// each cycle; directed scenarios pin the model with literal expectations.
module tb_ifu_prefetch;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clock          = 1'b0;
  logic        reset          = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        mem_req_valid;
  logic        mem_req_ready  = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid  = 1'b0;
  logic [31:0] mem_rsp_data   = '0;
  logic        inst_valid;
  logic        inst_ready     = 1'b0;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic [31:0] fetch_pc;

  ifu_prefetch #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_code      (inst_code),
    .inst_pc        (inst_pc),
    .fetch_pc       (fetch_pc)
  );

  always #5 clock = ~clock;

  // Model state: requests in flight (tagged with the epoch they were issued in)
  // and instructions waiting for decode.
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned epoch;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] code;
  } inst_t;

  req_t        pend[$];
  inst_t       mq[$];
  logic [31:0] m_fetch = RESET_PC;
  int unsigned epoch   = 0;
  int unsigned cyc     = 0;

  int checks   = 0;
  int failures = 0;

  // Stimulus knobs (percentages and response latency range).
  int unsigned rdy_pct   = 100;
  int unsigned rsp_pct   = 100;
  int unsigned ird_pct   = 100;
  int unsigned redir_pct = 0;
  int unsigned lat_min   = 1;
  int unsigned lat_max   = 1;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc    = '0;

  // Values observed in the most recent cycle.
  logic        o_req_valid;
  logic        o_req_fire;
  logic        o_inst_valid;
  logic [31:0] o_inst_pc;
  logic [31:0] o_fetch_pc;

  // Instruction memory contents as a fixed function of the address.
  function automatic logic [31:0] code_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 25) begin
        $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
      end
    end
  endtask

  // Assert reset mid-cycle, check the reset values at once, clear the model.
  task automatic do_reset(input bit check_now);
    #1;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    inst_ready     = 1'b0;
    #1;
    if (check_now) begin
      check("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst inst_valid",    32'(inst_valid),    32'd0);
      check("rst inst_code",     inst_code,          32'd0);
      check("rst inst_pc",       inst_pc,            32'd0);
      check("rst fetch_pc",      fetch_pc,           RESET_PC);
      check("rst mem_req_addr",  mem_req_addr,       RESET_PC);
    end
    pend.delete();
    mq.delete();
    m_fetch = RESET_PC;
    epoch++;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare every output
  // against the model, then advance the model to the next rising edge.
  task automatic cycle();
    bit          exp_req;
    bit          keep;
    inst_t       it;
    req_t        r;
    int unsigned lat;
    @(negedge clock);
    redirect_valid = force_redir || ($urandom_range(99) < redir_pct);
    if (force_redir) begin
      redirect_pc = force_pc;
    end else if ($urandom_range(9) == 0) begin
      redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    end else begin
      redirect_pc = 32'h0000_1000 + 32'($urandom_range(4095));
    end
    force_redir   = 1'b0;
    mem_req_ready = ($urandom_range(99) < rdy_pct);
    inst_ready    = ($urandom_range(99) < ird_pct);
    if (pend.size() != 0 && pend[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = code_of(pend[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    #1;
    exp_req = !redirect_valid && (mq.size() + pend.size() < DEPTH);
    check("mem_req_valid", 32'(mem_req_valid), 32'(exp_req));
    check("mem_req_addr", mem_req_addr, m_fetch);
    check("fetch_pc", fetch_pc, m_fetch);
    check("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("inst_pc", inst_pc, mq[0].pc);
      check("inst_code", inst_code, mq[0].code);
    end
    o_req_valid  = mem_req_valid;
    o_req_fire   = mem_req_valid && mem_req_ready;
    o_inst_valid = inst_valid;
    o_inst_pc    = inst_pc;
    o_fetch_pc   = fetch_pc;

    keep = 1'b0;
    if (mem_rsp_valid) begin
      r = pend.pop_front();
      if (r.epoch == epoch && !redirect_valid) begin
        keep    = 1'b1;
        it.pc   = r.addr;
        it.code = code_of(r.addr);
      end
    end
    if (redirect_valid) begin
      epoch++;
      mq.delete();
      m_fetch = {redirect_pc[31:2], 2'b00};
    end else begin
      if (inst_ready && mq.size() != 0) begin
        void'(mq.pop_front());
      end
      if (keep) begin
        mq.push_back(it);
      end
      if (exp_req && mem_req_ready) begin
        lat     = $urandom_range(lat_max, lat_min);
        r.addr  = m_fetch;
        r.due   = cyc + lat;
        r.epoch = epoch;
        pend.push_back(r);
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run_until_valid(input int max_cycles, output logic [31:0] pc_seen);
    bit found;
    found   = 1'b0;
    pc_seen = '0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      cycle();
      if (o_inst_valid) begin
        found   = 1'b1;
        pc_seen = o_inst_pc;
      end
    end
    check("first_valid_seen", 32'(found), 32'd1);
  endtask

  task automatic set_knobs(input int unsigned rdy, input int unsigned rsp, input int unsigned ird,
                           input int unsigned redir, input int unsigned lmin, input int unsigned lmax);
    rdy_pct   = rdy;
    rsp_pct   = rsp;
    ird_pct   = ird;
    redir_pct = redir;
    lat_min   = lmin;
    lat_max   = lmax;
  endtask

  initial begin
    logic [31:0] pc_seen;
    logic        vld  [12];
    logic [31:0] pcs  [12];
    logic [31:0] fpcs [12];
    logic        fire [12];
    int          nreq;
    bit          seen;

    // Sequential stream: 1-cycle responses, decode always ready.
    do_reset(1'b1);
    set_knobs(100, 100, 100, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      vld[i] = o_inst_valid;
      pcs[i] = o_inst_pc;
    end
    check("stream no bypass", 32'(vld[1]), 32'd0);
    check("stream pc0", pcs[2], 32'h0000_0100);
    check("stream pc1", pcs[3], 32'h0000_0104);
    check("stream pc2", pcs[4], 32'h0000_0108);
    check("stream consecutive", 32'({vld[2], vld[3], vld[4]}), 32'd7);

    // Decode stalled: exactly DEPTH requests, then the credit limit holds.
    do_reset(1'b1);
    set_knobs(100, 100, 0, 0, 1, 1);
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (o_req_fire) nreq++;
    end
    check("full request count", 32'(nreq), 32'd4);
    check("full mem_req_valid", 32'(o_req_valid), 32'd0);
    check("full inst_valid", 32'(o_inst_valid), 32'd1);
    check("full head pc", o_inst_pc, 32'h0000_0100);

    // Redirect with three requests outstanding.
    do_reset(1'b1);
    set_knobs(100, 100, 100, 0, 6, 6);
    for (int i = 0; i < 3; i++) cycle();
    force_redir = 1'b1;
    force_pc    = 32'h0000_2000;
    cycle();
    run_until_valid(40, pc_seen);
    check("drain first pc", pc_seen, 32'h0000_2000);

    // Redirect coinciding with a response and a consume, to an unaligned target.
    do_reset(1'b1);
    set_knobs(100, 100, 100, 0, 1, 1);
    for (int i = 0; i < 6; i++) cycle();
    force_redir = 1'b1;
    force_pc    = 32'h0000_3001;
    cycle();
    check("coincide pre valid", 32'(o_inst_valid), 32'd1);
    cycle();
    check("coincide flushed", 32'(o_inst_valid), 32'd0);
    run_until_valid(20, pc_seen);
    check("unaligned first pc", pc_seen, 32'h0000_3000);

    // Fetch address wraps from the top of the address space.
    force_redir = 1'b1;
    force_pc    = 32'hFFFF_FFF8;
    cycle();
    for (int i = 0; i < 12; i++) begin
      cycle();
      vld[i]  = o_inst_valid;
      pcs[i]  = o_inst_pc;
      fpcs[i] = o_fetch_pc;
      fire[i] = o_req_fire;
    end
    seen = 1'b0;
    for (int i = 0; i < 11 && !seen; i++) begin
      if (fpcs[i] == 32'hFFFF_FFFC && fire[i]) begin
        seen = 1'b1;
        check("wrap fetch_pc", fpcs[i + 1], 32'h0000_0000);
      end
    end
    check("wrap seen", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (vld[i]) begin
        seen = 1'b1;
        check("wrap first pc", pcs[i], 32'hFFFF_FFF8);
      end
    end
    check("wrap delivered", 32'(seen), 32'd1);

    // Reset in the middle of traffic with requests outstanding.
    do_reset(1'b1);
    set_knobs(100, 100, 0, 0, 2, 2);
    for (int i = 0; i < 4; i++) cycle();
    check("pre-reset busy", 32'(o_inst_valid), 32'd1);
    do_reset(1'b1);
    set_knobs(100, 100, 100, 0, 1, 3);
    run_until_valid(20, pc_seen);
    check("post-reset first pc", pc_seen, RESET_PC);

    // Randomized traffic with redirects, stalls and occasional resets.
    for (int blk = 0; blk < 12; blk++) begin
      if (blk % 4 == 3) do_reset(1'b1);
      set_knobs($urandom_range(100, 30), $urandom_range(100, 40), $urandom_range(100, 0),
                $urandom_range(8, 0), 1, $urandom_range(5, 1));
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(199) == 0) begin
          force_redir = 1'b1;
          force_pc    = 32'hFFFF_FFF4;
        end
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
